// File: rtl/slice_pkg.sv
// Constants and state encoding shared by the column scheduler, the slice
// datapath and the cos lookup table.
package slice_pkg;

    localparam int NUM_COLS    = 160;
    localparam int ANGLE_STEPS = 960;
    localparam int ANGLE_W     = 10;
    localparam int POS_W       = 13;
    localparam int TIMEOUT     = 4095;

    localparam int COL_W  = 8;
    localparam int BETA_W = 9;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LATCH = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_LATCH = ST_LATCH,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_DONE  = ST_DONE
    } sched_state_t;

    // Ray angle relative to screen centre: column index minus half the width.
    function automatic logic signed [BETA_W-1:0] col_to_beta(
        input logic [COL_W-1:0] c,
        input int               ncols
    );
        return $signed({1'b0, c}) - BETA_W'(ncols / 2);
    endfunction

endpackage

// File: rtl/angle_wrap_add.sv
// Combinational (a + signed b) mod ANGLE_STEPS for |b| < ANGLE_STEPS.
// Shared with the datapath ray-angle logic.
module angle_wrap_add #(
    parameter int ANGLE_W     = slice_pkg::ANGLE_W,
    parameter int ANGLE_STEPS = slice_pkg::ANGLE_STEPS,
    parameter int B_W         = slice_pkg::BETA_W
) (
    input  logic [ANGLE_W-1:0]    a,
    input  logic signed [B_W-1:0] b,
    output logic [ANGLE_W-1:0]    sum
);

    localparam int SW = ANGLE_W + 2;
    localparam logic signed [SW-1:0] STEPS = SW'(ANGLE_STEPS);

    logic signed [SW-1:0] raw;
    logic signed [SW-1:0] adj;

    // Two guard bits keep the raw sum in range; one correction suffices.
    always_comb begin
        raw = $signed({2'b00, a}) + SW'(b);
        adj = '0;
        if (raw[SW-1]) begin
            adj = STEPS;
        end else if (raw >= STEPS) begin
            adj = -STEPS;
        end
        sum = ANGLE_W'(raw + adj);
    end

endmodule

// File: rtl/slice_column_scheduler.sv
// Frame sequencer: snapshots the pose, then launches one slice per column left
// to right, waiting for each done pulse or a per-column timeout.
module slice_column_scheduler #(
    parameter int NUM_COLS    = slice_pkg::NUM_COLS,
    parameter int ANGLE_STEPS = slice_pkg::ANGLE_STEPS,
    parameter int ANGLE_W     = slice_pkg::ANGLE_W,
    parameter int POS_W       = slice_pkg::POS_W,
    parameter int TIMEOUT     = slice_pkg::TIMEOUT
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    frame_start,
    input  logic                    abort,
    input  logic signed [POS_W-1:0] player_x,
    input  logic signed [POS_W-1:0] player_y,
    input  logic [ANGLE_W-1:0]      player_angle,
    output logic                    slice_start,
    input  logic                    slice_done,
    output logic [7:0]              col,
    output logic signed [8:0]       beta,
    output logic [ANGLE_W-1:0]      alpha,
    output logic signed [POS_W-1:0] snap_x,
    output logic signed [POS_W-1:0] snap_y,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    aborted,
    output logic                    err_timeout,
    output logic [2:0]              dbg_state
);

    import slice_pkg::*;

    localparam int                     CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]             COL_LAST = 8'(NUM_COLS - 1);
    localparam logic signed [8:0]      BETA_RST = col_to_beta(8'd0, NUM_COLS);

    sched_state_t         state;
    logic [CNT_W-1:0]     wait_cnt;
    logic [ANGLE_W-1:0]   angle_snap;
    logic [7:0]           col_next;
    logic signed [8:0]    beta_next;
    logic [ANGLE_W-1:0]   angle_base;
    logic [ANGLE_W-1:0]   alpha_next;
    logic                 timeout_hit;
    logic                 last_col;

    // Handshake: slice_start is a one-cycle launch; the datapath answers with a
    // one-cycle slice_done, accepted only in WAIT. No backpressure either way.
    always_comb begin
        col_next    = (state == S_LATCH) ? 8'd0 : col + 8'd1;
        beta_next   = col_to_beta(col_next, NUM_COLS);
        angle_base  = (state == S_LATCH) ? player_angle : angle_snap;
        timeout_hit = (wait_cnt == CNT_LAST);
        last_col    = (col == COL_LAST);
    end

    angle_wrap_add #(
        .ANGLE_W    (ANGLE_W),
        .ANGLE_STEPS(ANGLE_STEPS),
        .B_W        (9)
    ) u_wrap (
        .a  (angle_base),
        .b  (beta_next),
        .sum(alpha_next)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            col         <= '0;
            beta        <= BETA_RST;
            alpha       <= '0;
            snap_x      <= '0;
            snap_y      <= '0;
            angle_snap  <= '0;
            wait_cnt    <= '0;
            slice_start <= 1'b0;
            frame_done  <= 1'b0;
            aborted     <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            slice_start <= 1'b0;
            frame_done  <= 1'b0;
            aborted     <= 1'b0;
            if (state != S_IDLE && abort) begin
                state   <= S_IDLE;
                busy    <= 1'b0;
                aborted <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (frame_start) begin
                            state       <= S_LATCH;
                            busy        <= 1'b1;
                            err_timeout <= 1'b0;
                        end
                    end
                    S_LATCH: begin
                        snap_x      <= player_x;
                        snap_y      <= player_y;
                        angle_snap  <= player_angle;
                        col         <= col_next;
                        beta        <= beta_next;
                        alpha       <= alpha_next;
                        slice_start <= 1'b1;
                        state       <= S_ISSUE;
                    end
                    S_ISSUE: begin
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end
                    S_WAIT: begin
                        // A done arriving in the last allowed cycle still counts.
                        if (slice_done || timeout_hit) begin
                            if (!slice_done) begin
                                err_timeout <= 1'b1;
                            end
                            if (last_col) begin
                                frame_done <= 1'b1;
                                state      <= S_DONE;
                            end else begin
                                col         <= col_next;
                                beta        <= beta_next;
                                alpha       <= alpha_next;
                                slice_start <= 1'b1;
                                state       <= S_ISSUE;
                            end
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_slice_column_scheduler.sv
// Randomized bench for slice_column_scheduler with a frame-level reference
// model: expected launch cycles, beta/alpha, snapshots, timeouts and aborts.
module tb_slice_column_scheduler;

    localparam int NC = 160;
    localparam int AS = 960;
    localparam int AW = 10;
    localparam int PW = 13;
    localparam int TO = 4095;
    localparam int BUDGET = 20000;

    logic                 clock;
    logic                 resetn;
    logic                 frame_start;
    logic                 abort;
    logic signed [PW-1:0] player_x;
    logic signed [PW-1:0] player_y;
    logic [AW-1:0]        player_angle;
    logic                 slice_start;
    logic                 slice_done;
    logic [7:0]           col;
    logic signed [8:0]    beta;
    logic [AW-1:0]        alpha;
    logic signed [PW-1:0] snap_x;
    logic signed [PW-1:0] snap_y;
    logic                 busy;
    logic                 frame_done;
    logic                 aborted;
    logic                 err_timeout;
    logic [2:0]           dbg_state;

    slice_column_scheduler #(
        .NUM_COLS(NC), .ANGLE_STEPS(AS), .ANGLE_W(AW), .POS_W(PW), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .resetn(resetn), .frame_start(frame_start), .abort(abort),
        .player_x(player_x), .player_y(player_y), .player_angle(player_angle),
        .slice_start(slice_start), .slice_done(slice_done), .col(col), .beta(beta),
        .alpha(alpha), .snap_x(snap_x), .snap_y(snap_y), .busy(busy),
        .frame_done(frame_done), .aborted(aborted), .err_timeout(err_timeout),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [7:0]           exp_q[$];
    int                   lat[NC];
    int                   cyc = 0;
    int                   f0, exp_done, next_issue, n_issued, last_c;
    int                   snap_ang, start_pulses;
    int                   frames_accepted = 0;
    int                   frames_done = 0;
    int                   mon_label, mon_c, mon_alpha;
    logic signed [PW-1:0] exp_sx, exp_sy;
    bit                   model_busy = 0;
    bit                   err_model = 0;
    bit                   err_pending = 0;
    bit                   aborted_exp = 0;

    always @(negedge clock) begin
        cyc++;
        if (!resetn) begin
            model_busy  = 0;
            err_model   = 0;
            err_pending = 0;
            aborted_exp = 0;
            exp_q.delete();
        end else if (model_busy) begin
            mon_label = cyc - f0;
            check("busy_run", busy, 1);
            if (aborted) check("stray_aborted", aborted, 0);
            if (slice_start) start_pulses++;
            if (mon_label == 1) check("err_cleared", err_timeout, 0);
            if (mon_label == next_issue && exp_q.size() > 0) begin
                err_model   = err_model | err_pending;
                err_pending = 0;
                mon_c       = int'(exp_q.pop_front());
                mon_alpha   = ((snap_ang + mon_c - NC / 2) % AS + AS) % AS;
                check("slice_start", slice_start, 1);
                check("col", col, mon_c);
                check("beta", beta, mon_c - NC / 2);
                check("alpha", alpha, mon_alpha);
                check("snap_x", snap_x, exp_sx);
                check("snap_y", snap_y, exp_sy);
                check("err_at_issue", err_timeout, err_model);
                if (lat[mon_c] == 0) err_pending = 1;
                next_issue += 1 + ((lat[mon_c] == 0) ? TO : lat[mon_c]);
                last_c = mon_c;
                n_issued++;
            end else if (slice_start) begin
                check("stray_start_label", mon_label, next_issue);
            end
            if (slice_done) check("col_hold", col, last_c);
            if (mon_label == exp_done) begin
                err_model   = err_model | err_pending;
                err_pending = 0;
                check("frame_done", frame_done, 1);
                check("err_at_done", err_timeout, err_model);
                model_busy = 0;
                frames_done++;
            end else if (frame_done) begin
                check("done_label", mon_label, exp_done);
            end
            if (abort && model_busy) begin
                model_busy  = 0;
                aborted_exp = 1;
            end
        end else begin
            check("idle_busy", busy, 0);
            check("idle_start", slice_start, 0);
            check("idle_done", frame_done, 0);
            check("aborted", aborted, aborted_exp);
            check("idle_err", err_timeout, err_model);
            aborted_exp = 0;
            if (frame_start) begin
                model_busy = 1;
                f0 = cyc;
                frames_accepted++;
                exp_q.delete();
                exp_done = 2;
                for (int c = 0; c < NC; c++) begin
                    exp_q.push_back(8'(c));
                    exp_done += 1 + ((lat[c] == 0) ? TO : lat[c]);
                end
                next_issue   = 2;
                n_issued     = 0;
                start_pulses = 0;
                snap_ang     = int'(player_angle);
                exp_sx       = player_x;
                exp_sy       = player_y;
                err_model    = 0;
                err_pending  = 0;
            end
        end
    end

    // ---------------- datapath responder ----------------
    int resp_n = 0;

    initial begin
        int l;
        slice_done = 1'b0;
        forever begin
            @(negedge clock);
            if (resetn && slice_start && resp_n < NC) begin
                l = lat[resp_n];
                resp_n++;
                if (l > 0) begin
                    repeat (l) @(posedge clock);
                    #1 slice_done = 1'b1;
                    @(posedge clock);
                    #1 slice_done = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_lat_random();
        for (int c = 0; c < NC; c++) lat[c] = $urandom_range(1, 5);
    endtask

    task automatic start_frame(input int ang);
        player_angle = AW'(ang);
        player_x     = PW'($urandom_range(0, 8191));
        player_y     = PW'($urandom_range(0, 8191));
        resp_n       = 0;
        frame_start  = 1'b1;
        tick(1);
        frame_start  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        tick(1);
        while (model_busy && i < BUDGET) begin
            tick(1);
            i++;
        end
        if (model_busy) check(tag, i, -1);
    endtask

    task automatic wait_issued(input int n, input string tag);
        int i;
        i = 0;
        while (n_issued < n && i < BUDGET) begin
            tick(1);
            i++;
        end
        if (n_issued < n) check(tag, n_issued, n);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_col"}, col, 0);
        check({tag, "_beta"}, beta, -(NC / 2));
        check({tag, "_alpha"}, alpha, 0);
        check({tag, "_snap_x"}, snap_x, 0);
        check({tag, "_snap_y"}, snap_y, 0);
        check({tag, "_start"}, slice_start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_aborted"}, aborted, 0);
        check({tag, "_err"}, err_timeout, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        resetn       = 1'b0;
        frame_start  = 1'b0;
        abort        = 1'b0;
        player_x     = '0;
        player_y     = '0;
        player_angle = '0;
        for (int c = 0; c < NC; c++) lat[c] = 3;
        tick(2);
        check_reset_vals("reset");
        resetn = 1'b1;

        // Idle: no frame_start for 100 cycles; abort in IDLE is ignored.
        tick(100);
        check("idle100_busy", busy, 0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(3);

        // Frame A: angle 0, fixed latency 3, with an ignored mid-frame request.
        start_frame(0);
        tick(100);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        wait_idle("a_budget");
        check("a_start_pulses", start_pulses, NC);
        check("a_done_label", exp_done, 642);
        check("a_frames", frames_done, 1);
        tick(5);

        // Frame B: angle 950, pose changes mid-frame must not matter.
        set_lat_random();
        start_frame(950);
        wait_issued(50, "b_issue_budget");
        player_angle = AW'(5);
        player_x     = PW'($urandom_range(0, 8191));
        wait_idle("b_budget");
        check("b_frames", frames_done, 2);
        tick(5);

        // Frame C: column 7 never completes.
        set_lat_random();
        lat[7] = 0;
        start_frame($urandom_range(0, AS - 1));
        wait_idle("c_budget");
        check("c_err_sticky", err_timeout, 1);
        check("c_frames", frames_done, 3);
        tick(5);

        // Frame D: abort during WAIT of column 40; an earlier request is ignored.
        set_lat_random();
        lat[40] = 30;
        start_frame($urandom_range(0, AS - 1));
        tick(20);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        wait_issued(41, "d_issue_budget");
        tick(3);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(60);
        check("d_no_frame_done", frames_done, 3);
        check("d_accepted", frames_accepted, 4);
        check("d_start_pulses", start_pulses, 41);

        // Frame E: asynchronous reset in the middle of column 100.
        set_lat_random();
        start_frame($urandom_range(0, AS - 1));
        wait_issued(101, "e_issue_budget");
        tick(1);
        #2 resetn = 1'b0;
        #1 check_reset_vals("async");
        tick(3);
        resetn = 1'b1;
        tick(20);

        // Frame F: a clean frame after reset starts again from column 0.
        set_lat_random();
        start_frame($urandom_range(0, AS - 1));
        wait_idle("f_budget");
        check("f_start_pulses", start_pulses, NC);
        check("f_frames", frames_done, 4);
        check("total_accepted", frames_accepted, 6);
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slice_column_scheduler.md
# slice_column_scheduler

Frame-level sequencer for the per-column raycast/slice datapath. On a frame request it snapshots the player pose, then walks the screen columns left to right. For each column it computes the ray's relative angle beta and its absolute angle alpha, issues one start pulse to the slice datapath and waits for that column's done pulse. It sits between the game/VGA frame logic and the slice datapath. It replaces ad-hoc column counters with one owner of column order, pose coherency and stall recovery.

## Interface
Parameters:
- NUM_COLS, 160: screen columns per frame.
- ANGLE_STEPS, 960: angle units per full turn. Angle input and alpha output lie in 0..ANGLE_STEPS-1.
- ANGLE_W, 10: width of the angle and alpha buses.
- POS_W, 13: width of the signed player coordinates.
- TIMEOUT, 4095: maximum number of WAIT cycles per column before the column is skipped.

Ports:
- clock, in, 1: sole clock, rising edge.
- resetn, in, 1: asynchronous, active-low reset.
- frame_start, in, 1: single-cycle request to render one frame.
- abort, in, 1: level; cancels the frame in progress.
- player_x, player_y, in, POS_W signed: live player position.
- player_angle, in, ANGLE_W: live view angle.
- slice_start, out, 1: one-cycle pulse that launches a column.
- slice_done, in, 1: one-cycle pulse from the datapath marking column complete.
- col, out, 8: current column index.
- beta, out, 9 signed: col - NUM_COLS/2.
- alpha, out, ANGLE_W: (angle_snap + beta) mod ANGLE_STEPS.
- snap_x, snap_y, out, POS_W signed: latched position, held for the whole frame.
- busy, out, 1: high in every state except IDLE.
- frame_done, out, 1: one-cycle pulse after the last column completes.
- aborted, out, 1: one-cycle pulse when an abort is taken.
- err_timeout, out, 1: sticky; set on any column timeout, cleared by the next accepted frame_start.

## Operation
States and transitions:
- IDLE: frame_start → LATCH. Clears err_timeout.
- LATCH: captures player_x, player_y and player_angle into the snap registers. Sets col=0. → ISSUE.
- ISSUE: slice_start=1 for exactly one cycle. → WAIT.
- WAIT: the wait counter increments each cycle.
  - On slice_done, or when the counter reaches TIMEOUT (also sets err_timeout): if col==NUM_COLS-1 → DONE, else col+1 → ISSUE.
  - If slice_done and the timeout coincide, slice_done wins and err_timeout is not set.
- DONE: frame_done=1 for one cycle. → IDLE.
- abort in any non-IDLE state → IDLE on the next edge. Emits aborted for one cycle and no frame_done. abort in IDLE is ignored.

Other rules:
- frame_start outside IDLE is ignored. It is not queued.
- slice_done outside WAIT is ignored.
- col, beta, alpha, snap_x and snap_y are registered. They change only on entry to ISSUE or LATCH and are stable from the slice_start cycle until slice_done.
- Changes to player_* after LATCH have no effect until the next frame.

Alpha arithmetic:
- Compute sum = angle_snap + beta at ANGLE_W+2 bits signed.
- If sum<0, add ANGLE_STEPS. If sum≥ANGLE_STEPS, subtract ANGLE_STEPS.
- A single correction is sufficient because |beta| < ANGLE_STEPS.

## Timing
Reset values: state=IDLE, col=0, beta=-NUM_COLS/2, alpha=0, snap_x=0, snap_y=0. All pulse outputs are 0, busy=0 and err_timeout=0.

Latency:
- frame_start sampled at cycle 0 → LATCH at cycle 1 → first slice_start at cycle 2.
- With a datapath done latency of L cycles after slice_start (L≥1), each column takes 1+L cycles.
- frame_done is asserted at cycle 2 + NUM_COLS·(1+L).
- busy rises the cycle after frame_start is sampled and falls the cycle after frame_done.

Reset mid-frame: reset clears everything immediately (asynchronous). No pulse is emitted.

## Structure
- Shared package (slice_pkg): NUM_COLS, ANGLE_STEPS, ANGLE_W, POS_W and the state encoding localparams (IDLE..DONE, 3 bits). The slice datapath and the cos lookup table use the same constants.
- One natural sub-module is angle_wrap_add. It is combinational, computes (a + signed b) mod ANGLE_STEPS, and is reusable by the datapath's ray-angle logic. Everything else is flat.

## Test plan
- Reset, then idle: all outputs equal their reset values, and busy stays 0 over 100 cycles while no frame_start is given.
- player_angle=0, datapath model L=3:
  - col 0 gives beta=-80, alpha=880; col 80 gives alpha=0; col 159 gives alpha=79.
  - Exactly 160 slice_start pulses occur, and frame_done is asserted at cycle 642.
- player_angle=950: col 90 gives beta=10, alpha=0 (wrap from 960). player_angle is then changed to 5 mid-frame, and alpha continues from the snapshot.
- The datapath never returns done for col 7:
  - After TIMEOUT WAIT cycles, err_timeout=1 and col 8 issues.
  - The frame completes, and the next frame_start clears err_timeout.
- abort during WAIT of col 40: aborted pulses, busy=0 next cycle, and no frame_done. A frame_start given while busy earlier was ignored (exactly one frame counted).
- resetn asserted during col 100: all outputs return to reset values asynchronously, and a new frame then starts at col 0.
